rdy_ack_receiver: RTL

// - Receiving side of an asynchronous RDY/ACK link; sits directly downstream of synchronizer.
// - Consumes the synchronized RDY transition indicator and the stable message data.
// - Buffers accepted messages in a FIFO and presents them to the local consumer via valid/taken.
// - Returns an ACK transition indicator to the remote sender, one toggle per accepted message.

---
 rtl/rdy_ack_receiver.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rdy_ack_receiver.sv
// Receiving end of an asynchronous RDY/ACK link: accepts synchronized RDY toggles into a small FIFO.
// Optional RX_STATS_EN adds msg_cnt/stall_cnt statistics outputs.
module rdy_ack_receiver #(
  parameter int N        = 8,
  parameter int LOGDEPTH = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rdy_in,
  input  logic [N-1:0]        data_in,
  output logic                ack_out,
  output logic [N-1:0]        out_data,
  output logic                out_valid,
  input  logic                out_taken,
  output logic [LOGDEPTH:0]   count
`ifdef RX_STATS_EN
  ,
  output logic [15:0]         msg_cnt,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int                D       = 2 ** LOGDEPTH;
  localparam logic [LOGDEPTH:0] DEPTH_C = (LOGDEPTH + 1)'(D);

  logic                ack_q,    ack_d;
  logic                exp_q,    exp_d;
  logic [LOGDEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOGDEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOGDEPTH:0]   count_q,  count_d;
  logic [N-1:0]        mem_q [D];
  logic [N-1:0]        mem_d [D];

  logic pend;
  logic pop;
  logic accept;

  // A full FIFO may still accept when a pop frees the head slot on the same edge.
  always_comb begin
    pend   = (rdy_in != exp_q);
    pop    = out_taken && (count_q != '0);
    accept = pend && ((count_q < DEPTH_C) || ((count_q == DEPTH_C) && pop));
  end

  always_comb begin
    ack_d    = ack_q;
    exp_d    = exp_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (accept) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + LOGDEPTH'(1);
      exp_d           = ~exp_q;
      ack_d           = ~ack_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + LOGDEPTH'(1);
    end
    if (accept && !pop) begin
      count_d = count_q + (LOGDEPTH + 1)'(1);
    end else if (pop && !accept) begin
      count_d = count_q - (LOGDEPTH + 1)'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_q    <= 1'b0;
      exp_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < D; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ack_q    <= ack_d;
      exp_q    <= exp_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // The head is forced to zero while empty so stale entries never leak out.
  always_comb begin
    out_data = '0;
    if (count_q != '0) begin
      out_data = mem_q[rd_ptr_q];
    end
  end

  assign ack_out   = ack_q;
  assign out_valid = (count_q != '0);
  assign count     = count_q;

`ifdef RX_STATS_EN
  logic [15:0] msg_cnt_q,   msg_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Both statistics saturate rather than wrap.
  always_comb begin
    msg_cnt_d   = msg_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept && (msg_cnt_q != 16'hFFFF)) begin
      msg_cnt_d = msg_cnt_q + 16'd1;
    end
    if (pend && !accept && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      msg_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      msg_cnt_q   <= msg_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign msg_cnt   = msg_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
